// File: rtl/jtcop_obj_dma.sv
// jtcop_obj_dma: vblank-synchronous copy of CPU sprite RAM into a double-buffered object table.
module jtcop_obj_dma #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          LVBL,
  input  logic          dma_req,
  output logic [AW-1:0] dma_addr,
  input  logic [15:0]   dma_dout,
  output logic          dma_busy,
  input  logic [AW-1:0] tbl_addr,
  output logic [15:0]   tbl_dout,
  output logic          buf_sel
);
  typedef enum logic [1:0] {IDLE, COPY, SWAP} state_t;
  state_t        st_q;
  logic [15:0]   mem [0:2**(AW+1)-1];
  logic [AW:0]   cnt_q;
  logic [AW-1:0] wa;
  logic          lvl_q, pend_q, ran_q, pend, rise, start, wr;
  assign pend  = pend_q | dma_req;
  assign rise  = LVBL & ~lvl_q;
  assign start = st_q == IDLE && pend && !LVBL && !ran_q;
  // cycle k of the copy stores the word fetched for address k-1
  assign wr    = st_q == COPY && |cnt_q;
  assign wa    = cnt_q[AW-1:0] - 1'b1;
  always_ff @(posedge clk) begin
    if (wr) mem[{~buf_sel, wa}] <= dma_dout;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      lvl_q    <= 1'b0;
      pend_q   <= 1'b0;
      ran_q    <= 1'b0;
      dma_addr <= '0;
      dma_busy <= 1'b0;
      tbl_dout <= '0;
      buf_sel  <= 1'b0;
    end else begin
      lvl_q    <= LVBL;
      tbl_dout <= mem[{buf_sel, tbl_addr}];
      ran_q    <= start ? 1'b1 : rise ? 1'b0 : ran_q;
      pend_q   <= start ? 1'b0 : (st_q == COPY && rise) ? 1'b1 : pend;
      case (st_q)
        IDLE: if (start) begin
          st_q     <= COPY;
          cnt_q    <= '0;
          dma_addr <= '0;
          dma_busy <= 1'b1;
        end
        COPY: if (rise) begin
          st_q     <= IDLE;
          dma_addr <= '0;
          dma_busy <= 1'b0;
        end else if (cnt_q[AW]) begin
          st_q     <= SWAP;
          dma_busy <= 1'b0;
        end else begin
          cnt_q    <= cnt_q + 1'b1;
          dma_addr <= &dma_addr ? dma_addr : dma_addr + 1'b1;
        end
        SWAP: begin
          st_q     <= IDLE;
          buf_sel  <= ~buf_sel;
          dma_addr <= '0;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtcop_obj_dma.sv
// tb_jtcop_obj_dma: frame-level model of the object DMA checked every cycle, plus literal spot checks.
module tb_jtcop_obj_dma;
  logic        clk = 0, rst_n = 0, LVBL = 1, dma_req = 0;
  logic [9:0]  dma_addr, tbl_addr = 0;
  logic [15:0] dma_dout, tbl_dout;
  logic        dma_busy, buf_sel;
  logic [15:0] cpu_ram [1024];
  int          total = 0, pass = 0;

  jtcop_obj_dma #(.AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .dma_req(dma_req),
    .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_busy(dma_busy),
    .tbl_addr(tbl_addr), .tbl_dout(tbl_dout), .buf_sel(buf_sel)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) dma_dout <= cpu_ram[dma_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: a copy occupies busy for 1025 clks, then the whole CPU RAM appears
  // in the hidden buffer and the exposed buffer flips on the following clk.
  logic [15:0] mbuf [2][1024];
  bit          m_valid [2];
  bit          m_busy, m_swap, m_pend, m_ran, m_lvl, m_sel, m_tv;
  bit          e_rise, e_pend, e_start;
  int          m_age;
  logic [9:0]  m_addr;
  logic [15:0] m_td;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_swap = 0; m_pend = 0; m_ran = 0; m_lvl = 0;
      m_sel = 0; m_addr = 0; m_tv = 0;
    end else begin
      e_rise  = LVBL && !m_lvl;
      e_pend  = m_pend || dma_req;
      e_start = !m_busy && !m_swap && e_pend && !LVBL && !m_ran;
      m_td = mbuf[m_sel][tbl_addr];
      m_tv = m_valid[m_sel];
      m_pend = e_pend;
      if (m_swap) begin
        m_sel = !m_sel; m_swap = 0; m_addr = 0;
      end else if (m_busy) begin
        if (e_rise) begin
          m_busy = 0; m_pend = 1; m_addr = 0;
        end else begin
          m_age++;
          m_addr = m_age > 1023 ? 10'd1023 : m_age[9:0];
          if (m_age == 1025) begin
            for (int i = 0; i < 1024; i++) mbuf[!m_sel][i] = cpu_ram[i];
            m_valid[!m_sel] = 1; m_busy = 0; m_swap = 1;
          end
        end
      end else if (e_start) begin
        m_busy = 1; m_age = 0; m_addr = 0; m_pend = 0; m_valid[!m_sel] = 0;
      end
      if (e_start) m_ran = 1;
      else if (e_rise) m_ran = 0;
      m_lvl = LVBL;
    end
  end

  int rises = 0, run = 0, last_run = 0;
  bit pb = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("busy", dma_busy, m_busy);
      chk("buf_sel", buf_sel, m_sel);
      chk("dma_addr", dma_addr, m_addr);
      if (m_tv) chk("tbl_dout", tbl_dout, m_td);
    end
    if (dma_busy) begin
      if (!pb) begin rises++; run = 0; end
      run++;
    end else if (pb) last_run = run;
    pb = dma_busy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic fill(input logic [15:0] p);
    for (int i = 0; i < 1024; i++) cpu_ram[i] = 16'(i) ^ p;
  endtask
  task automatic req();
    dma_req = 1; tick(1); dma_req = 0;
  endtask
  task automatic blank();
    LVBL = 0; tick(1100);
  endtask
  task automatic active();
    LVBL = 1; tick(200);
  endtask

  initial begin
    m_valid[0] = 0; m_valid[1] = 0;
    fill(16'hA5A5);
    tick(3);
    chk("rst busy", dma_busy, 0);
    chk("rst buf_sel", buf_sel, 0);
    chk("rst dma_addr", dma_addr, 0);
    chk("rst tbl_dout", tbl_dout, 0);
    rst_n = 1;
    tick(10); req(); tick(20);
    LVBL = 0; tick(1);
    chk("busy after edge", dma_busy, 1);
    tick(1099);
    chk("copy1 busy len", last_run, 1025);
    chk("copy1 buf_sel", buf_sel, 1);
    chk("copy1 count", rises, 1);
    tbl_addr = 10'h3FF; tick(1);
    chk("copy1 word 3ff", tbl_dout, 16'hA65A);
    active();
    fill(16'h1234);
    tbl_addr = 10'd5;
    req(); tick(30); req(); tick(30); req(); tick(30);
    blank();
    chk("triple req count", rises, 2);
    chk("triple buf_sel", buf_sel, 0);
    chk("triple word 5", tbl_dout, 16'h1231);
    active();
    fill(16'hFFFF);
    blank(); active(); blank(); active();
    chk("no req count", rises, 2);
    chk("no req buf_sel", buf_sel, 0);
    chk("no req word 5", tbl_dout, 16'h1231);
    req(); tick(10);
    LVBL = 0; tick(500);
    chk("abort busy pre", dma_busy, 1);
    LVBL = 1; tick(1);
    chk("abort busy", dma_busy, 0);
    chk("abort buf_sel", buf_sel, 0);
    tick(1);
    chk("abort word 5", tbl_dout, 16'h1231);
    tick(200);
    blank();
    chk("retry count", rises, 4);
    chk("retry busy len", last_run, 1025);
    chk("retry buf_sel", buf_sel, 1);
    chk("retry word 5", tbl_dout, 16'hFFFA);
    active();
    LVBL = 0; dma_req = 1; tick(1); dma_req = 0;
    chk("simul busy", dma_busy, 1);
    tick(1099);
    chk("simul buf_sel", buf_sel, 0);
    active(); blank();
    chk("simul no second", rises, 5);
    chk("simul buf_sel stays", buf_sel, 0);
    chk("simul word 5", tbl_dout, 16'hFFFA);
    active(); req(); blank();
    chk("pre-reset buf_sel", buf_sel, 1);
    active(); req(); LVBL = 0; tick(100);
    chk("mid copy busy", dma_busy, 1);
    #2 rst_n = 0;
    #1;
    chk("async rst busy", dma_busy, 0);
    chk("async rst buf_sel", buf_sel, 0);
    chk("async rst dma_addr", dma_addr, 0);
    tick(3);
    rst_n = 1;
    tick(20);
    chk("post rst count", rises, 7);
    LVBL = 1; tick(10);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
